// File: rtl/ecc_rmw_merge_buf.sv
// rtl/ecc_rmw_merge_buf.sv - RMW merge buffer holding corrected read data until the write path fetches it
module ecc_rmw_merge_buf #(
    parameter int TCQ                   = 100,
    parameter int DATA_WIDTH            = 64,
    parameter int nCK_PER_CLK           = 4,
    parameter int DATA_BUF_ADDR_WIDTH   = 4,
    parameter int DATA_BUF_OFFSET_WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rmw_capture,
    input  logic [DATA_BUF_ADDR_WIDTH-1:0]   rmw_addr,
    input  logic [DATA_BUF_OFFSET_WIDTH-1:0] rmw_offset,
    input  logic [2*nCK_PER_CLK*DATA_WIDTH-1:0] rmw_data,
    input  logic                             merge_rd,
    input  logic [DATA_BUF_ADDR_WIDTH-1:0]   merge_addr,
    input  logic [DATA_BUF_OFFSET_WIDTH-1:0] merge_offset,
    output logic [2*nCK_PER_CLK*DATA_WIDTH-1:0] rd_merge_data,
    output logic                             rd_merge_valid,
    output logic                             fill_err,
    output logic                             miss_err,
    output logic [DATA_BUF_ADDR_WIDTH+DATA_BUF_OFFSET_WIDTH:0] occupancy
);

    localparam int IDXW = DATA_BUF_ADDR_WIDTH + DATA_BUF_OFFSET_WIDTH;
    localparam int N    = 2 ** IDXW;
    localparam int W    = 2 * nCK_PER_CLK * DATA_WIDTH;

    // TCQ is accepted for drop-in compatibility only; registers here carry no modelled delay.
    if (TCQ < 0) begin : g_tcq_unused
    end

    logic [W-1:0]    mem [N];
    logic [N-1:0]    valid_q;
    logic [N-1:0]    valid_nxt;
    logic [IDXW-1:0] cap_idx;
    logic [IDXW-1:0] rd_idx;
    logic            same_idx;
    logic            cap_hit;
    logic            rd_hit;
    logic            occ_inc;
    logic            occ_dec;

    assign cap_idx  = {rmw_addr, rmw_offset};
    assign rd_idx   = {merge_addr, merge_offset};
    assign same_idx = rmw_capture && merge_rd && (cap_idx == rd_idx);
    assign cap_hit  = valid_q[cap_idx];
    assign rd_hit   = valid_q[rd_idx];

    // A bypassed capture never lands in the valid map: the entry is consumed the same cycle.
    assign occ_inc = rmw_capture && !cap_hit && !same_idx;
    assign occ_dec = merge_rd && rd_hit;

    always_comb begin
        valid_nxt = valid_q;
        if (rmw_capture && !same_idx) begin
            valid_nxt[cap_idx] = 1'b1;
        end
        if (merge_rd) begin
            valid_nxt[rd_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rmw_capture) begin
            mem[cap_idx] <= rmw_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= '0;
            rd_merge_data  <= '0;
            rd_merge_valid <= 1'b0;
            fill_err       <= 1'b0;
            miss_err       <= 1'b0;
            occupancy      <= '0;
        end else begin
            valid_q   <= valid_nxt;
            occupancy <= occupancy + {{IDXW{1'b0}}, occ_inc} - {{IDXW{1'b0}}, occ_dec};
            fill_err  <= rmw_capture && cap_hit;
            miss_err  <= merge_rd && !rd_hit && !same_idx;
            if (merge_rd) begin
                if (same_idx) begin
                    rd_merge_data  <= rmw_data;
                    rd_merge_valid <= 1'b1;
                end else if (rd_hit) begin
                    rd_merge_data  <= mem[rd_idx];
                    rd_merge_valid <= 1'b1;
                end else begin
                    rd_merge_data  <= '0;
                    rd_merge_valid <= 1'b0;
                end
            end else begin
                rd_merge_valid <= 1'b0;
            end
        end
    end

endmodule
